rr_line_encoder: RTL and testbench
==================================

# rr_line_encoder

Sequential 8-to-3 request encoder: the collecting end of the line fan-out built by the existing `decoder`/`multiplexor` pair. It latches event pulses arriving on individual one-hot lines and presents them one at a time as a binary line index with a valid/ready handshake, so the downstream can route or acknowledge them. Unlike the purely combinational `coder`, simultaneous requests are never OR-merged into a bogus code. They are queued per line and served in round-robin order.

## Interface
- `N`, default 8: number of request lines; power of two, 2..256.
- `W`, default `$clog2(N)` (3): code width; localparam, not overridable.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-high reset.
- `I`  in  N: request lines; a 1 sampled on any clock edge raises that line's pending bit.
- `Y`  out  W: index of the line currently offered.
- `valid`  out  1: `Y` holds a valid pending index.
- `ready`  in  1: downstream accepts `Y` on an edge where `valid & ready`.
- `pending`  out  N: registered pending-request vector.
- `lost`  out  1: one-cycle pulse; a request arrived on a line that was already pending and was not being served (events merged).

## Operation
- All state is registered; no combinational path from `I` or `ready` to any output.
- Pending bit `i`, next value: `I[i] | (pending[i] & ~clr[i])`, where `clr[i] = valid & ready & (Y == i)`.
  - Set and clear on the same edge: set wins; bit stays 1; `lost` not raised.
- `lost`, next value: OR over `i` of `I[i] & pending[i] & ~clr[i]`.
- Round-robin pointer `ptr` (W bits): on accept, `ptr <= Y + 1` mod N; wraps 7 -> 0 for N = 8.
- Selection: lowest index `i >= ptr` with `pending[i]`. If there is none, lowest pending index overall (wrap-around).
- FSM, two states:
  - IDLE: `valid = 0`. If `pending != 0`, register the selected index into `Y`, set `valid`, go to OFFER. Otherwise stay.
  - OFFER: `valid = 1`; `Y` frozen. On `ready`, clear that pending bit, update `ptr`, deassert `valid`, return to IDLE. Without `ready`, stay.
- While `valid & ~ready`, `Y` and `valid` are stable regardless of new requests, including lower-index lines.
- `Y` keeps its last value in IDLE; it is only meaningful when `valid = 1`.
- Reset (any state, including mid-OFFER):
  - `pending = 0`, `ptr = 0`, state IDLE, `valid = 0`, `Y = 0`, `lost = 0`.
  - The offered code is discarded. `I` sampled on the reset edge is ignored.

## Timing
- Latency: `I[i]` high at edge t -> `pending[i] = 1` after t -> `valid = 1`, `Y = i` after edge t+1 (2 edges) when idle.
- Handshake: transfer on the edge with `valid & ready`. `valid` is low for at least one cycle after every transfer.
- Peak throughput: one code per 2 cycles with `ready` held high.
- `ready` may be high while `valid` is low; it has no effect then.
- `lost` is valid the cycle after the offending edge and lasts one cycle per offending edge.
- An accepted line re-requested on the accept edge is re-offered no earlier than every other pending line (pointer has moved past it).

## Structure
- Shared package `line_pkg`:
  - `LINES = 8`
  - `CODE_W = 3`
  - state enum `{ST_IDLE, ST_OFFER}`
  - Reuse it in future line-routing blocks.
- Sub-module `rr_pick`: combinational; inputs `pending[N]`, `ptr[W]`; outputs `idx[W]`, `found`. Implements the rotate-then-priority-encode selection. Instantiated once.
- Top: pending register, `lost` logic, FSM, `ptr`/`Y` registers.

## Test plan
- Single request: pulse `I = 8'b0001_0000` for 1 cycle, `ready = 1` -> `valid` 2 edges later with `Y = 4`. After transfer, `pending = 0` and `valid = 0`.
- Simultaneous: from reset, `I = 8'b0010_1000` for 1 cycle, `ready = 1` -> `Y = 3`, then after the bubble `Y = 5`, then idle.
- Wrap-around: serve line 5 (`ptr = 6`), then pend lines 1 and 7 together -> order `Y = 7`, then `Y = 1`; `ptr` ends at 2.
- Backpressure: offer `Y = 6` with `ready = 0` for 5 cycles while pulsing `I[0]` -> `Y = 6` and `valid = 1` stable throughout. When `ready` rises, 6 transfers, then `Y = 0` is offered.
- Lost and set-wins:
  - Pend line 2; pulse `I[2]` again while line 2 is not offered -> `lost = 1` for exactly 1 cycle.
  - Pulse `I[2]` on its accept edge -> `lost = 0`; `pending[2]` remains 1.
- Reset mid-operation: `rst = 1` for 1 cycle during OFFER with `pending = 8'hFF` -> next cycle all outputs 0. A subsequent single request is served from `ptr = 0` ordering.

Source files
------------

// File: rtl/line_pkg.sv
// ============================================================================
// Module      : line_pkg
// Description : Shared constants and types for the line-routing blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package line_pkg;

   localparam int LINES  = 8;
   localparam int CODE_W = 3;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } state_t;

endpackage : line_pkg

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Round-robin selector: lowest pending index at or above ptr,
//               wrapping to the lowest pending index overall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
   import line_pkg::*;
#(
   parameter int N = LINES,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] pending,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] idx,
   output logic         found
);

   logic [W-1:0] cand;

   // Scan from the farthest offset down so the nearest offset from ptr wins;
   // N is a power of two, so W-bit wrap of ptr + k is exactly mod N.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = ptr + W'(k);
         if (pending[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule : rr_pick

`default_nettype wire

// File: rtl/rr_line_encoder.sv
// ============================================================================
// Module      : rr_line_encoder
// Description : Latches one-hot request pulses and offers them one at a time
//               as a binary index over valid/ready, in round-robin order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_line_encoder
   import line_pkg::*;
#(
   parameter  int N = LINES,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] I,
   output logic [W-1:0] Y,
   output logic         valid,
   input  logic         ready,
   output logic [N-1:0] pending,
   output logic         lost
);

   state_t       state_q, state_d;
   logic [N-1:0] pending_q, pending_d;
   logic [W-1:0] ptr_q, ptr_d;
   logic [W-1:0] y_q, y_d;
   logic         lost_q, lost_d;

   logic [N-1:0] clr;
   logic [W-1:0] pick_idx;
   logic         pick_found;

   rr_pick #(
      .N (N),
      .W (W)
   ) u_pick (
      .pending (pending_q),
      .ptr     (ptr_q),
      .idx     (pick_idx),
      .found   (pick_found)
   );

   // A new request on the line being accepted wins over the clear.
   always_comb begin
      clr = '0;
      if ((state_q == ST_OFFER) && ready) begin
         clr[y_q] = 1'b1;
      end
      pending_d = I | (pending_q & ~clr);
      lost_d    = |(I & pending_q & ~clr);
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      y_d     = y_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               y_d     = pick_idx;
               state_d = ST_OFFER;
            end
         end
         ST_OFFER: begin
            if (ready) begin
               ptr_d   = y_q + W'(1);
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         ptr_q     <= '0;
         y_q       <= '0;
         lost_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         ptr_q     <= ptr_d;
         y_q       <= y_d;
         lost_q    <= lost_d;
      end
   end

   assign Y       = y_q;
   assign valid   = (state_q == ST_OFFER);
   assign pending = pending_q;
   assign lost    = lost_q;

endmodule : rr_line_encoder

`default_nettype wire

// File: tb/tb_rr_line_encoder.sv
// ============================================================================
// Module      : tb_rr_line_encoder
// Description : Directed bench for rr_line_encoder with immediate assertions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_line_encoder;

   logic       clk;
   logic       rst;
   logic [7:0] I;
   logic [2:0] Y;
   logic       valid;
   logic       ready;
   logic [7:0] pending;
   logic       lost;

   int checks = 0;
   int errors = 0;

   rr_line_encoder #(.N(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .I       (I),
      .Y       (Y),
      .valid   (valid),
      .ready   (ready),
      .pending (pending),
      .lost    (lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; I = '0; ready = 1'b0;
      step(); step();
      rst = 1'b0;
      chk("rst_valid", valid, 0);
      chk("rst_Y", Y, 0);
      chk("rst_pending", pending, 0);
      chk("rst_lost", lost, 0);

      // Single request on line 4
      I = 8'h10; ready = 1'b1;
      step(); I = '0;
      chk("single_pend", pending, 8'h10);
      chk("single_valid_lat", valid, 0);
      step();
      chk("single_valid", valid, 1);
      chk("single_Y", Y, 4);
      step();
      chk("single_after_valid", valid, 0);
      chk("single_after_pend", pending, 0);

      // Simultaneous lines 3 and 5 from reset
      rst = 1'b1; step(); rst = 1'b0;
      I = 8'h28; ready = 1'b1;
      step(); I = '0;
      step();
      chk("simul_first", Y, 3);
      chk("simul_first_v", valid, 1);
      step();
      chk("simul_bubble", valid, 0);
      step();
      chk("simul_second", Y, 5);
      chk("simul_second_v", valid, 1);
      step(); step();
      chk("simul_idle_v", valid, 0);
      chk("simul_idle_p", pending, 0);

      // Wrap-around: ptr = 6, lines 1 and 7
      I = 8'h82;
      step(); I = '0;
      step();
      chk("wrap_first", Y, 7);
      step(); step();
      chk("wrap_second", Y, 1);
      step();
      // ptr should now be 2: lines 1 and 3 -> 3 first
      I = 8'h0A;
      step(); I = '0;
      step();
      chk("wrap_ptr2_first", Y, 3);
      step(); step();
      chk("wrap_ptr2_second", Y, 1);
      step();

      // Backpressure on line 6 while pulsing line 0
      ready = 1'b0; I = 8'h40;
      step(); I = '0;
      step();
      chk("bp_offer_Y", Y, 6);
      for (int k = 0; k < 5; k++) begin
         I = (k % 2 == 0) ? 8'h01 : 8'h00;
         step();
         chk("bp_hold_Y", Y, 6);
         chk("bp_hold_v", valid, 1);
      end
      I = '0; ready = 1'b1;
      step();
      chk("bp_xfer_v", valid, 0);
      chk("bp_xfer_pend", pending, 8'h01);
      step();
      chk("bp_next_Y", Y, 0);
      chk("bp_next_v", valid, 1);
      step();

      // Lost: lines 1 and 2 pending, line 1 offered, re-pulse line 2
      ready = 1'b0; I = 8'h06;
      step(); I = '0;
      step();
      chk("lost_offer_Y", Y, 1);
      chk("lost_pre", lost, 0);
      I = 8'h04;
      step(); I = '0;
      chk("lost_pulse", lost, 1);
      step();
      chk("lost_one_cycle", lost, 0);
      ready = 1'b1;
      step();
      step();
      chk("setwin_offer_Y", Y, 2);
      I = 8'h04;
      step(); I = '0;
      chk("setwin_lost", lost, 0);
      chk("setwin_pend", pending, 8'h04);
      chk("setwin_valid", valid, 0);
      step();
      chk("setwin_reoffer", Y, 2);
      chk("setwin_reoffer_v", valid, 1);
      step();
      chk("setwin_done_p", pending, 0);

      // Reset mid-offer with all lines pending
      ready = 1'b0; I = 8'hFF;
      step(); I = '0;
      step();
      chk("midrst_pre_p", pending, 8'hFF);
      chk("midrst_pre_v", valid, 1);
      rst = 1'b1; I = 8'hFF;
      step(); rst = 1'b0; I = '0;
      chk("midrst_valid", valid, 0);
      chk("midrst_Y", Y, 0);
      chk("midrst_pend", pending, 0);
      chk("midrst_lost", lost, 0);
      ready = 1'b1; I = 8'h22;
      step(); I = '0;
      step();
      chk("midrst_first", Y, 1);
      step(); step();
      chk("midrst_second", Y, 5);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_rr_line_encoder

`default_nettype wire
